// File: rtl/tec8_pkg.sv
// Shared constants for the TEC-8 datapath.
// Holds the one-hot beat encodings, beat phase count and T3 phase index, and the ALU
// select codes decoded by tec8_alu.
package tec8_pkg;

  // Beat phases: 0..3, the T3 strobe is phase 2, W advances on the phase-3 edge.
  localparam int unsigned PhaseCount = 4;
  localparam logic [1:0]  PhaseT3    = 2'd2;
  localparam logic [1:0]  PhaseLast  = 2'(PhaseCount - 1);

  // One-hot beat (W) encodings.
  localparam logic [2:0] BeatW1 = 3'b001;
  localparam logic [2:0] BeatW2 = 3'b010;
  localparam logic [2:0] BeatW3 = 3'b100;

  // Arithmetic select codes (M = 0).
  localparam logic [3:0] AluInc = 4'b0000;
  localparam logic [3:0] AluAdd = 4'b1001;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluDec = 4'b1111;

  // Logic select codes (M = 1).
  localparam logic [3:0] AluPassB = 4'b1010;
  localparam logic [3:0] AluAnd   = 4'b1011;
  localparam logic [3:0] AluOr    = 4'b1110;
  localparam logic [3:0] AluXor   = 4'b0110;
  localparam logic [3:0] AluPassA = 4'b1111;

endpackage

// File: rtl/tec8_alu.sv
// Combinational 8-bit ALU of the TEC-8 datapath.
// Ports: a_i/b_i operands, s_i select code, m_i mode (0 arithmetic, 1 logic),
//        cin_i carry control (active-low: carry-in = ~cin_i), f_o result, co_o carry-out.
module tec8_alu
  import tec8_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [3:0] s_i,
  input  logic       m_i,
  input  logic       cin_i,
  output logic [7:0] f_o,
  output logic       co_o
);

  logic       c0;
  logic [8:0] sum;

  always_comb begin
    c0   = ~cin_i;
    sum  = {1'b0, a_i} + {8'h00, c0};
    f_o  = a_i;
    co_o = 1'b0;
    if (!m_i) begin
      case (s_i)
        AluInc:  sum = {1'b0, a_i} + {8'h00, c0};
        AluAdd:  sum = {1'b0, a_i} + {1'b0, b_i} + {8'h00, c0};
        AluSub:  sum = {1'b0, a_i} + {1'b0, ~b_i} + {8'h00, c0};
        AluDec:  sum = {1'b0, a_i} + 9'h0FF + {8'h00, c0};
        default: sum = {1'b0, a_i} + {8'h00, c0};
      endcase
      f_o  = sum[7:0];
      co_o = sum[8];
    end else begin
      case (s_i)
        AluPassB: f_o = b_i;
        AluAnd:   f_o = a_i & b_i;
        AluOr:    f_o = a_i | b_i;
        AluXor:   f_o = a_i ^ b_i;
        AluPassA: f_o = a_i;
        default:  f_o = a_i;
      endcase
    end
  end

endmodule

// File: rtl/tec8_datapath.sv
// TEC-8 datapath: beat sequencer (phase, running, W), register file R0..R3, PC, AR, IR,
// C/Z flags, bus multiplexer and memory interface.
// Ports: CLK/CLR clock and async active-high clear; control strobes from the controller;
//        S/M/CIN ALU control; SEL/D/START console; IR/C/Z/W/T3 status to the controller;
//        MEM_* memory port (combinational read); PC/AR/DBUS observation.
module tec8_datapath
  import tec8_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       SELCTL,
  input  logic       DRW,
  input  logic       LPC,
  input  logic       PCINC,
  input  logic       PCADD,
  input  logic       LAR,
  input  logic       ARINC,
  input  logic       LIR,
  input  logic       LDZ,
  input  logic       LDC,
  input  logic       CIN,
  input  logic       M,
  input  logic       MEMW,
  input  logic       ABUS,
  input  logic       SBUS,
  input  logic       MBUS,
  input  logic       STOP,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic [3:0] S,
  input  logic [3:0] SEL,
  input  logic [7:0] D,
  input  logic       START,
  output logic [7:0] IR,
  output logic       C,
  output logic       Z,
  output logic [2:0] W,
  output logic       T3,
  output logic [7:0] MEM_ADDR,
  output logic [7:0] MEM_WDATA,
  output logic       MEM_WE,
  input  logic [7:0] MEM_RDATA,
  output logic [7:0] PC,
  output logic [7:0] AR,
  output logic [7:0] DBUS
);

  logic [1:0] phase_q, phase_d;
  logic       run_q, run_d;
  logic [2:0] w_q, w_d;
  logic [7:0] r_q [4];
  logic [7:0] r_d [4];
  logic [7:0] pc_q, pc_d, ar_q, ar_d, ir_q, ir_d;
  logic       c_q, c_d, z_q, z_d;

  logic       t3;
  logic [1:0] rd, rs;
  logic [7:0] alu_f, dbus;
  logic       alu_co;

  assign t3 = run_q && (phase_q == PhaseT3);
  assign rd = SELCTL ? SEL[3:2] : ir_q[3:2];
  assign rs = SELCTL ? SEL[1:0] : ir_q[1:0];

  tec8_alu u_alu (
    .a_i   (r_q[rd]),
    .b_i   (r_q[rs]),
    .s_i   (S),
    .m_i   (M),
    .cin_i (CIN),
    .f_o   (alu_f),
    .co_o  (alu_co)
  );

  always_comb begin
    if (ABUS)      dbus = alu_f;
    else if (SBUS) dbus = D;
    else if (MBUS) dbus = MEM_RDATA;
    else           dbus = 8'h00;
  end

  // Sequencer: START only matters while stopped; W and STOP act on the phase-3 edge.
  always_comb begin
    phase_d = phase_q;
    run_d   = run_q;
    w_d     = w_q;
    if (!run_q) begin
      if (START) begin
        run_d   = 1'b1;
        phase_d = 2'd0;
      end
    end else if (phase_q == PhaseLast) begin
      phase_d = 2'd0;
      if (STOP) begin
        run_d = 1'b0;
        w_d   = BeatW1;
      end else begin
        case (w_q)
          BeatW1:  w_d = SHORT ? BeatW1 : BeatW2;
          BeatW2:  w_d = LONG ? BeatW3 : BeatW1;
          BeatW3:  w_d = BeatW1;
          default: w_d = BeatW1;
        endcase
      end
    end else begin
      phase_d = phase_q + 2'd1;
    end
  end

  always_comb begin
    r_d = r_q;
    if (DRW) r_d[rd] = dbus;
    ir_d = LIR ? MEM_RDATA : ir_q;
    if (LPC)        pc_d = dbus;
    else if (PCADD) pc_d = pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
    else if (PCINC) pc_d = pc_q + 8'd1;
    else            pc_d = pc_q;
    if (LAR)        ar_d = dbus;
    else if (ARINC) ar_d = ar_q + 8'd1;
    else            ar_d = ar_q;
    c_d = LDC ? alu_co : c_q;
    z_d = LDZ ? (alu_f == 8'h00) : z_q;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      phase_q <= 2'd0;
      run_q   <= 1'b0;
      w_q     <= BeatW1;
      r_q     <= '{default: 8'h00};
      pc_q    <= 8'h00;
      ar_q    <= 8'h00;
      ir_q    <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      run_q   <= run_d;
      w_q     <= w_d;
      // Every datapath load lands on the edge that ends the T3 phase.
      if (t3) begin
        r_q  <= r_d;
        pc_q <= pc_d;
        ar_q <= ar_d;
        ir_q <= ir_d;
        c_q  <= c_d;
        z_q  <= z_d;
      end
    end
  end

  // IR fetch addresses memory with the current (pre-increment) PC.
  assign MEM_ADDR  = LIR ? pc_q : ar_q;
  assign MEM_WDATA = dbus;
  assign MEM_WE    = MEMW & t3;
  assign IR        = ir_q;
  assign C         = c_q;
  assign Z         = z_q;
  assign W         = w_q;
  assign T3        = t3;
  assign PC        = pc_q;
  assign AR        = ar_q;
  assign DBUS      = dbus;

endmodule

// File: doc/tec8_datapath.md
TEC8_DATAPATH -- requirements
Module: tec8_datapath

Interface
REQ-001 SHALL have ports: CLK in 1 (master clock); CLR in 1 (reset, asynchronous, active-high).
REQ-002 SHALL have control inputs, 1 bit each: SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC, CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG.
REQ-003 SHALL have inputs S in 4 (ALU select); SEL in 4 (console register select); D in 8 (console data switches); START in 1 (console start, one-CLK pulse).
REQ-004 SHALL have outputs IR out 8 (IR[7:4] feeds the controller); C out 1; Z out 1; W out 3 (one-hot beat); T3 out 1 (beat strobe).
REQ-005 SHALL have memory ports MEM_ADDR out 8; MEM_WDATA out 8; MEM_WE out 1; MEM_RDATA in 8 (combinational read), plus observation outputs PC out 8, AR out 8, DBUS out 8.

Function
REQ-006 Beat: 4 phases (0..3) counted on CLK; T3=1 only in phase 2 while running.
REQ-007 All datapath register and flag loads SHALL occur on the CLK edge ending phase 2 of a running beat; no loads while stopped.
REQ-008 W SHALL change only on the edge ending phase 3: W1->W1 if SHORT, else W2; W2->W3 if LONG, else W1; W3->W1; SHORT/LONG sampled at that edge.
REQ-009 STOP=1 at the phase-3 edge SHALL clear running, force W=001, phase=0; START while stopped sets running with phase 0; START while running ignored.
REQ-010 Register select: RD = SELCTL ? SEL[3:2] : IR[3:2]; RS = SELCTL ? SEL[1:0] : IR[1:0]; A=R[RD], B=R[RS].
REQ-011 ALU (carry-in = ~CIN), M=0: S=0000 F=A+cin; 1001 F=A+B+cin; 0110 F=A+~B+cin; 1111 F=A+8'hFF+cin; other S as 0000.
REQ-012 ALU M=1: S=1010 F=B; 1011 F=A&B; 1110 F=A|B; 0110 F=A^B; 1111 and all others F=A.
REQ-013 Carry-out = bit 8 of the 9-bit arithmetic sum; 0 when M=1; LDC loads C=carry-out; LDZ loads Z=(F==0).
REQ-014 DBUS = ABUS?F : SBUS?D : MBUS?MEM_RDATA : 8'h00 (fixed priority ABUS>SBUS>MBUS).
REQ-015 DRW writes R[RD]<=DBUS; LIR loads IR<=MEM_RDATA; LAR loads AR<=DBUS.
REQ-016 PC priority LPC (PC<=DBUS) > PCADD (PC<=PC+sign-extended IR[3:0]) > PCINC (PC<=PC+1); all mod 256.
REQ-017 AR priority LAR > ARINC (AR<=AR+1, mod 256).
REQ-018 MEM_ADDR = LIR ? PC : AR; MEM_WDATA = DBUS; MEM_WE = MEMW & T3.
REQ-019 LIR with PCINC on the same edge SHALL fetch from the pre-increment PC.

Reset
REQ-020 CLR=1 SHALL immediately, at any phase, force R0..R3=0, PC=0, AR=0, IR=0, C=0, Z=0, W=001, phase=0, running=0, T3=0, MEM_WE=0.
REQ-021 After CLR release, no beat SHALL run until START.

Structure
REQ-022 Shared package tec8_pkg SHALL hold W one-hot constants, phase count (4), T3 phase index, ALU S-code constants.
REQ-023 ALU SHALL be a combinational sub-module tec8_alu (A, B, S, M, CIN -> F, carry-out).
REQ-024 Sequencer (phase, running, W) and datapath registers SHALL stay in tec8_datapath.

Verification
REQ-025 CLR pulse mid-phase 1 -> W=001, T3=0, PC=AR=IR=00, C=Z=0 same cycle; no T3 until START.
REQ-026 START, SHORT=1, SBUS=1, LPC=1, D=8'h3C, STOP=0 -> one T3 every 4 CLK; PC=3C after beat 1; W stays 001.
REQ-027 LONG=1 held, SHORT=0 -> W 001,010,100,001; LONG=0 -> W 001,010,001.
REQ-028 R1=F0, R2=20, IR=8'h16, S=1001, M=0, CIN=1, ABUS, DRW, LDC, LDZ at W2 -> R1=10, C=1, Z=0.
REQ-029 R1=R2=55, IR=8'h16, S=0110, M=0, CIN=0, ABUS, LDZ, LDC -> F=00, Z=1, C=1; PC=FE, IR[3:0]=3, PCADD -> PC=01.
REQ-030 STOP=1 at end of W2 -> running=0, W=001, T3 silent; next START runs W1; MEMW at W3 with AR=40 -> single MEM_WE pulse, MEM_ADDR=40.
